key_rsp_shifter: RTL
====================

KEY_RSP_SHIFTER -- requirements
Module: key_rsp_shifter

Interface
REQ-001 Parameter NBITS, default 8: response bits collected per transaction (1..15).
REQ-002 Parameter GAP, default 2: idle cycles after each bit strobe (1..7).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  transaction request; sampled only in IDLE.
REQ-006 cmd  input  4  probe nibble, driven onto key_addr for the whole transaction.
REQ-007 sdrd  input  1  serial response from the key device; valid only while key_sel is high.
REQ-008 key_sel  output  1  key access qualifier; high means the access condition is active.
REQ-009 key_addr  output  4  probe address bits BA7..BA4 to the key device.
REQ-010 data  output  NBITS  last completed response, MSB = first bit received.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when data is updated.
REQ-013 perr  output  1  parity error flag; present only with KEY_PARITY_EN.

Function
REQ-020 The FSM SHALL have the states IDLE, SETUP, STROBE, SAMPLE, GAP and DONE.
REQ-021 In IDLE with start=1, the block SHALL latch cmd, clear the bit counter and the shift register, and enter SETUP.
REQ-022 SETUP: key_addr = latched cmd, key_sel = 0; 1 cycle; next state STROBE.
REQ-023 STROBE: key_sel = 1; 1 cycle, which lets the key register the access; next state SAMPLE.
REQ-024 SAMPLE: key_sel = 1; the shift register SHALL shift left with sdrd entering the LSB; the bit counter increments; next state GAP.
REQ-025 GAP: key_sel = 0 for exactly GAP cycles, then SETUP if bits remain, otherwise DONE.
REQ-026 DONE: data <= shift register, done = 1, 1 cycle; next state IDLE.
REQ-027 Each bit SHALL take 3+GAP cycles, so done is high in cycle 1 + NBITS*(3+GAP) after the start edge (cycle 41 at the defaults).
REQ-028 key_addr SHALL be stable from SETUP through the end of GAP of each bit, and SHALL be 0 in IDLE.
REQ-029 start while busy SHALL be ignored; it is neither queued nor aborting.
REQ-030 data SHALL hold its value between DONE pulses and SHALL never show partial shifts.
REQ-031 start asserted in the cycle done is high SHALL be ignored; start is accepted from the following IDLE cycle.
REQ-032 sdrd SHALL be sampled only in SAMPLE; its value in all other states SHALL have no effect.

Reset
REQ-040 On rst=1 at a clock edge, the state SHALL become IDLE, and key_sel, key_addr, data, done, busy and perr SHALL all be 0 after that edge.
REQ-041 rst SHALL override any state, including mid-strobe; key_sel SHALL drop at the same edge and no done pulse is produced.
REQ-042 rst and start high together SHALL result in reset (IDLE, no transaction).

Configuration
REQ-050 Macro KEY_PARITY_EN defined: each transaction SHALL collect NBITS+1 bits, with the final bit being odd parity over the response; data SHALL take the first NBITS bits; perr SHALL be set at DONE if the parity fails and cleared at the next DONE with good parity; latency SHALL be 1+(NBITS+1)*(3+GAP).
REQ-051 Macro KEY_PARITY_EN undefined: the perr port SHALL be absent, and NBITS bits SHALL be collected per REQ-027.

Verification
REQ-060 Defaults, cmd=4'hA, sdrd model returns 1,0,1,1,0,0,1,0 -> data=8'hB2, done in cycle 41, key_addr=4'hA whenever key_sel=1.
REQ-061 Check the key_sel waveform -> exactly 8 two-cycle high pulses, each separated by exactly 3 low cycles (GAP=2 plus SETUP).
REQ-062 start pulsed again at cycle 10 of a transaction -> ignored; exactly one done pulse and 8 strobes.
REQ-063 rst asserted during the 4th STROBE -> key_sel=0, busy=0 next cycle, data unchanged from 0, no done; a following start completes normally.
REQ-064 sdrd toggling outside SAMPLE, held 1 in SAMPLE -> data=8'hFF.
REQ-065 KEY_PARITY_EN, response 8'hB2 with parity bit 1 -> perr=0; parity bit 0 -> perr=1; done in cycle 46.

Source files
------------

// File: rtl/key_rsp_shifter.sv
// Purpose: bit-serial key response reader; per bit it drives SETUP, a 2-cycle key_sel
//          strobe (STROBE, SAMPLE) and GAP idle cycles, shifting sdrd in MSB-first.
// Latency: done pulses 1 + NBITS*(3+GAP) cycles after the start edge
//          (1 + (NBITS+1)*(3+GAP) with KEY_PARITY_EN).
// Backpressure: none; start is only honoured in IDLE, and is ignored while busy or done.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, cmd       transaction request and probe nibble (latched on acceptance)
//   sdrd             serial response, sampled only in SAMPLE
//   key_sel          access qualifier (high in STROBE and SAMPLE)
//   key_addr         latched cmd while a bit is in progress, 0 otherwise
//   data, done       last completed response (MSB = first bit) and its one-cycle pulse
//   busy             high in every state except IDLE
//   perr             odd-parity error flag, only when KEY_PARITY_EN is defined
//
// Optional feature macro: KEY_PARITY_EN (adds a trailing odd-parity bit and the perr port).
module key_rsp_shifter #(
    parameter int NBITS = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       cmd,
    input  logic             sdrd,
    output logic             key_sel,
    output logic [3:0]       key_addr,
    output logic [NBITS-1:0] data,
    output logic             busy,
`ifdef KEY_PARITY_EN
    output logic             perr,
`endif
    output logic             done
);

`ifdef KEY_PARITY_EN
    localparam int NCOL = NBITS + 1;
`else
    localparam int NCOL = NBITS;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cmd_q;
    logic [NCOL-1:0]  shift_q;
    logic [4:0]       bit_cnt_q;
    logic [2:0]       gap_cnt_q;
    logic [NBITS-1:0] data_q;
`ifdef KEY_PARITY_EN
    logic             perr_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SETUP;
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_GAP;
            S_GAP: begin
                if (gap_cnt_q == 3'(GAP - 1))
                    state_d = (bit_cnt_q == 5'(NCOL)) ? S_DONE : S_SETUP;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= 4'd0;
            shift_q   <= '0;
            bit_cnt_q <= 5'd0;
            gap_cnt_q <= 3'd0;
            data_q    <= '0;
`ifdef KEY_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cmd_q     <= cmd;
                        bit_cnt_q <= 5'd0;
                        shift_q   <= '0;
                    end
                end
                S_SAMPLE: begin
                    // Truncating cast drops the old MSB; works for NCOL == 1 too.
                    shift_q   <= NCOL'({shift_q, sdrd});
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                    gap_cnt_q <= 3'd0;
                end
                S_GAP: begin
                    gap_cnt_q <= gap_cnt_q + 3'd1;
                    // Load on entry to DONE so data is already valid while done is high.
                    if (state_d == S_DONE) begin
                        data_q <= shift_q[NCOL-1 -: NBITS];
`ifdef KEY_PARITY_EN
                        // Odd parity: an even count of ones over all bits is an error.
                        perr_q <= ~(^shift_q);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_sel  = (state_q == S_STROBE) || (state_q == S_SAMPLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign key_addr = (state_q == S_SETUP || state_q == S_STROBE ||
                       state_q == S_SAMPLE || state_q == S_GAP) ? cmd_q : 4'd0;
    assign data     = data_q;
`ifdef KEY_PARITY_EN
    assign perr     = perr_q;
`endif

endmodule
